// File: rtl/fc_ibuf.sv
// rtl/fc_ibuf.sv - MLP layer input buffer: captures func-unit activations, then
// streams them LSB-first as bit-planes onto the CIM crossbar rows.
module fc_ibuf #(
  parameter int DATA_SIZE         = 8,
  parameter int INPUT_NEURONS     = 512,
  parameter int XBAR_SIZE         = 256,
  parameter int NUM_CHANNELS      = 1,
  parameter int ELEMENTS_PER_TILE = XBAR_SIZE / DATA_SIZE,
  parameter int PREV_H_TILES      = (INPUT_NEURONS + ELEMENTS_PER_TILE - 1) / ELEMENTS_PER_TILE,
  parameter int NUM_ADDR          = (ELEMENTS_PER_TILE + NUM_CHANNELS - 1) / NUM_CHANNELS,
  parameter int V_CIM_TILES       = (INPUT_NEURONS + XBAR_SIZE - 1) / XBAR_SIZE,
  parameter int BIT_W             = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic [PREV_H_TILES-1:0][NUM_CHANNELS-1:0][DATA_SIZE-1:0] i_data,
  input  logic                                                    i_write_enable,
  input  logic                                                    i_start,
  output logic                                                    o_ready,
  output logic [V_CIM_TILES-1:0][XBAR_SIZE-1:0]                   o_cim_data,
  output logic [BIT_W-1:0]                                        o_cim_bit,
  output logic                                                    o_cim_valid,
  output logic                                                    o_cim_last,
  input  logic                                                    i_cim_ready
);

  localparam int ADDR_W = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;

  typedef enum logic {S_IBUF_EMPTY, S_IBUF_STREAM} state_t;

  state_t                                  r_state;
  logic [ADDR_W-1:0]                       r_addr;
  logic [BIT_W-1:0]                        r_bit;
  logic                                    r_ready;
  logic                                    r_valid;
  logic                                    r_last;
  logic                                    w_wr;
  logic [INPUT_NEURONS-1:0][DATA_SIZE-1:0] w_elems;

  assign w_wr = (r_state == S_IBUF_EMPTY) && i_write_enable;

  // Each element has a fixed (lane, address, channel) source; lanes that map
  // past the tile or past INPUT_NEURONS simply have no element to land in.
  for (genvar e = 0; e < INPUT_NEURONS; e++) begin : g_elem
    localparam int H = e / ELEMENTS_PER_TILE;
    localparam int L = e % ELEMENTS_PER_TILE;
    localparam int A = L / NUM_CHANNELS;
    localparam int C = L % NUM_CHANNELS;
    logic [DATA_SIZE-1:0] r_val;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_val <= '0;
      end else if (w_wr && (r_addr == ADDR_W'(A))) begin
        r_val <= i_data[H][C];
      end
    end

    assign w_elems[e] = r_val;
  end

  for (genvar v = 0; v < V_CIM_TILES; v++) begin : g_tile
    for (genvar r = 0; r < XBAR_SIZE; r++) begin : g_row
      localparam int E = v * XBAR_SIZE + r;
      if (E < INPUT_NEURONS) begin : g_on
        assign o_cim_data[v][r] = r_valid & w_elems[E][r_bit];
      end else begin : g_off
        assign o_cim_data[v][r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IBUF_EMPTY;
      r_addr  <= '0;
      r_bit   <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IBUF_EMPTY: begin
          if (i_write_enable) begin
            r_addr <= (r_addr == ADDR_W'(NUM_ADDR - 1)) ? '0 : r_addr + 1'b1;
          end
          // Start wins over the address advance; a same-cycle write still lands.
          if (i_start) begin
            r_state <= S_IBUF_STREAM;
            r_addr  <= '0;
            r_bit   <= '0;
            r_ready <= 1'b0;
            r_valid <= 1'b1;
            r_last  <= (DATA_SIZE == 1);
          end
        end
        S_IBUF_STREAM: begin
          if (i_cim_ready) begin
            if (r_last) begin
              r_state <= S_IBUF_EMPTY;
              r_bit   <= '0;
              r_ready <= 1'b1;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
            end else begin
              r_bit  <= r_bit + 1'b1;
              r_last <= ((r_bit + 1'b1) == BIT_W'(DATA_SIZE - 1));
            end
          end
        end
        default: r_state <= S_IBUF_EMPTY;
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_cim_valid = r_valid;
  assign o_cim_last  = r_last;
  assign o_cim_bit   = r_bit;

endmodule

// File: tb/tb_fc_ibuf.sv
// tb/tb_fc_ibuf.sv - self-checking bench for fc_ibuf in the small
// configuration (DATA_SIZE=4, 20 neurons, 16-row crossbar, 2 channels).
module tb_fc_ibuf;

  localparam int DS  = 4;
  localparam int IN  = 20;
  localparam int XB  = 16;
  localparam int NC  = 2;
  localparam int EPT = XB / DS;
  localparam int PHT = 5;
  localparam int NA  = 2;
  localparam int VT  = 2;

  logic                           clk = 1'b0;
  logic                           rst = 1'b1;
  logic [PHT-1:0][NC-1:0][DS-1:0] i_data = '0;
  logic                           i_write_enable = 1'b0;
  logic                           i_start = 1'b0;
  logic                           o_ready;
  logic [VT-1:0][XB-1:0]          o_cim_data;
  logic [1:0]                     o_cim_bit;
  logic                           o_cim_valid;
  logic                           o_cim_last;
  logic                           i_cim_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the stored vector and the write address
  int m_mem [IN];
  int m_addr = 0;

  fc_ibuf #(
    .DATA_SIZE    (DS),
    .INPUT_NEURONS(IN),
    .XBAR_SIZE    (XB),
    .NUM_CHANNELS (NC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_data        (i_data),
    .i_write_enable(i_write_enable),
    .i_start       (i_start),
    .o_ready       (o_ready),
    .o_cim_data    (o_cim_data),
    .o_cim_bit     (o_cim_bit),
    .o_cim_valid   (o_cim_valid),
    .o_cim_last    (o_cim_last),
    .i_cim_ready   (i_cim_ready)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_plane(input int b);
    logic [31:0] p;
    p = '0;
    for (int e = 0; e < VT * XB; e++)
      if (e < IN) p[e] = ((m_mem[e] >> b) & 1) != 0;
    return p;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, 64'(o_ready), 64'd1);
    chk({tag, "_valid"}, 64'(o_cim_valid), 64'd0);
    chk({tag, "_last"}, 64'(o_cim_last), 64'd0);
    chk({tag, "_bit"}, 64'(o_cim_bit), 64'd0);
    chk({tag, "_data"}, 64'(o_cim_data), 64'd0);
  endtask

  function automatic void model_clear();
    for (int e = 0; e < IN; e++) m_mem[e] = 0;
    m_addr = 0;
  endfunction

  // One cycle in the empty state: optional write of d, optional start
  task automatic drive_fill(input logic [PHT-1:0][NC-1:0][DS-1:0] d, input bit we, input bit st);
    i_data = d;
    i_write_enable = we;
    i_start = st;
    if (we) begin
      for (int h = 0; h < PHT; h++)
        for (int c = 0; c < NC; c++) begin
          int l, e;
          l = m_addr * NC + c;
          e = h * EPT + l;
          if (l < EPT && e < IN) m_mem[e] = int'(d[h][c]);
        end
      m_addr = (m_addr + 1) % NA;
    end
    if (st) m_addr = 0;
    cyc();
    i_write_enable = 1'b0;
    i_start = 1'b0;
  endtask

  function automatic logic [PHT-1:0][NC-1:0][DS-1:0] rand_data();
    logic [PHT-1:0][NC-1:0][DS-1:0] d;
    for (int h = 0; h < PHT; h++)
      for (int c = 0; c < NC; c++) d[h][c] = DS'($urandom);
    return d;
  endfunction

  // Follows a stream from its first plane to the return to empty.
  task automatic run_stream(input string tag, input logic [31:0] pat, input bit use_pat, input bit noise);
    int  b = 0;
    int  k = 0;
    bit  rdy;
    logic [PHT-1:0][NC-1:0][DS-1:0] ones;
    for (int h = 0; h < PHT; h++)
      for (int c = 0; c < NC; c++) ones[h][c] = '1;
    forever begin
      chk({tag, "_valid"}, 64'(o_cim_valid), 64'd1);
      chk({tag, "_ready"}, 64'(o_ready), 64'd0);
      chk({tag, "_bit"}, 64'(o_cim_bit), 64'(b));
      chk({tag, "_last"}, 64'(o_cim_last), 64'(b == DS - 1));
      chk({tag, "_data"}, 64'(o_cim_data), 64'(exp_plane(b)));
      rdy = use_pat ? pat[k] : ($urandom_range(0, 2) != 0);
      i_cim_ready = rdy;
      if (noise) begin
        i_data = ones;
        i_write_enable = 1'($urandom);
        i_start = 1'($urandom);
      end
      cyc();
      k++;
      if (rdy) begin
        if (b == DS - 1) break;
        b++;
      end
      if (k > 200) begin
        chk({tag, "_timeout"}, 64'(k), 64'd0);
        break;
      end
    end
    i_cim_ready = 1'b0;
    i_write_enable = 1'b0;
    i_start = 1'b0;
    check_idle({tag, "_done"});
    cyc();
    chk({tag, "_nosecond"}, 64'(o_cim_valid), 64'd0);
  endtask

  initial begin
    logic [PHT-1:0][NC-1:0][DS-1:0] d;
    model_clear();

    // Reset values, and i_cim_ready ignored while empty
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    check_idle("reset");
    i_cim_ready = 1'b1;
    cyc();
    check_idle("empty_rdy");
    i_cim_ready = 1'b0;

    // Fill with element index values and stream with ready held high
    for (int h = 0; h < PHT; h++)
      for (int c = 0; c < NC; c++) d[h][c] = DS'(h * 4 + c);
    drive_fill(d, 1'b1, 1'b0);
    for (int h = 0; h < PHT; h++)
      for (int c = 0; c < NC; c++) d[h][c] = DS'(h * 4 + 2 + c);
    drive_fill(d, 1'b1, 1'b0);
    chk("fill_ready", 64'(o_ready), 64'd1);
    drive_fill(d, 1'b0, 1'b1);
    run_stream("fill", 32'hFFFF_FFFF, 1'b1, 1'b0);

    // Back-pressure pattern 1,0,0,1,0,1,1 (LSB first)
    drive_fill(d, 1'b0, 1'b1);
    run_stream("bp", 32'b110_1001, 1'b1, 1'b0);

    // Wrap: addr 0,1,0 with the third write coinciding with start
    drive_fill(rand_data(), 1'b1, 1'b0);
    drive_fill(rand_data(), 1'b1, 1'b0);
    drive_fill(rand_data(), 1'b1, 1'b1);
    run_stream("wrap", 32'hFFFF_FFFF, 1'b1, 1'b0);

    // Writes and starts during the stream are ignored
    drive_fill(rand_data(), 1'b1, 1'b1);
    run_stream("ignore", 32'h0, 1'b0, 1'b1);

    // Randomised fills and stall patterns
    for (int t = 0; t < 6; t++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) drive_fill(rand_data(), 1'b1, 1'b0);
      drive_fill(rand_data(), 1'($urandom), 1'b1);
      run_stream("rand", 32'h0, 1'b0, 1'($urandom));
    end

    // Asynchronous reset mid-stream at bit 2
    drive_fill(rand_data(), 1'b1, 1'b1);
    i_cim_ready = 1'b1;
    cyc();
    cyc();
    chk("arst_pre_bit", 64'(o_cim_bit), 64'd2);
    i_cim_ready = 1'b0;
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check_idle("arst");
    cyc();
    rst = 1'b0;
    cyc();
    check_idle("arst_rel");
    drive_fill(d, 1'b0, 1'b1);
    run_stream("zero", 32'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fc_ibuf.md
Name: fc_ibuf

Overview:
- Input buffer of an MLP layer, on the receiving side of the func unit → input-buffer write interface.
- Captures post-ReLU activations written by the upstream func unit, one address per write-enable cycle.
- On the upstream start pulse it stops accepting writes and streams the stored vector into the CIM crossbar rows bit-serially, LSB first, with a valid/ready handshake.
- Deasserts o_ready while holding unconsumed data, so upstream back-pressures.

Parameters:
- DATA_SIZE, 8, activation width in bits.
- INPUT_NEURONS, 512, number of activations in this layer's input vector.
- XBAR_SIZE, 256, crossbar rows per CIM tile.
- NUM_CHANNELS, 1, elements written per upstream H-tile per cycle.
- ELEMENTS_PER_TILE, XBAR_SIZE/DATA_SIZE, elements per upstream H-tile.
- PREV_H_TILES, ceil(INPUT_NEURONS/ELEMENTS_PER_TILE), upstream H-tiles (write lanes).
- NUM_ADDR, ceil(ELEMENTS_PER_TILE/NUM_CHANNELS), write addresses per fill.
- V_CIM_TILES, ceil(INPUT_NEURONS/XBAR_SIZE), this layer's vertical CIM tiles.
- BIT_W, max(1, clog2(DATA_SIZE)), bit-index width.

Ports:
- clk  in  1  clock.
- rst  in  1  **asynchronous, active-high reset**.
- i_data  in  [PREV_H_TILES][NUM_CHANNELS] x DATA_SIZE  activations from the func unit.
- i_write_enable  in  1  i_data valid for the current write address.
- i_start  in  1  upstream fill complete.
- o_ready  out  1  buffer empty and accepting writes (to upstream i_next_ready).
- o_cim_data  out  [V_CIM_TILES][XBAR_SIZE] x 1  current bit-plane onto crossbar rows.
- o_cim_bit  out  BIT_W  index of the bit-plane presented.
- o_cim_valid  out  1  bit-plane valid.
- o_cim_last  out  1  presented plane is bit DATA_SIZE-1.
- i_cim_ready  in  1  CIM accepts the plane this cycle.

Behaviour:
- States:
  - s_ibuf_empty: o_ready=1, writes accepted.
  - s_ibuf_stream: o_ready=0, bit-planes presented.
- Reset (async assert, synchronous deassert use):
  - state=empty; write address=0; bit counter=0; storage cleared to 0.
  - o_ready=1; o_cim_valid=0; o_cim_last=0; o_cim_bit=0; o_cim_data=0.
- Write addressing:
  - Write in empty with i_write_enable=1 stores i_data[h][c] into element e = h*ELEMENTS_PER_TILE + addr*NUM_CHANNELS + c.
  - Lanes are discarded when addr*NUM_CHANNELS+c >= ELEMENTS_PER_TILE or e >= INPUT_NEURONS.
  - addr increments per write; wraps NUM_ADDR-1→0, overwriting earlier data.
  - Elements not rewritten keep prior contents.
- Fill complete:
  - i_start in empty moves to stream next cycle; addr resets to 0.
  - A write in the same cycle as i_start is stored first.
- Streaming outputs:
  - o_cim_valid=1 in stream.
  - o_cim_data[v][r] = bit o_cim_bit of element v*XBAR_SIZE+r.
  - Rows with index >= INPUT_NEURONS are driven 0.
  - o_cim_last = (o_cim_bit == DATA_SIZE-1).
  - Latency: first plane is valid the cycle after i_start.
- Handshake:
  - Plane transfers when o_cim_valid && i_cim_ready; bit counter then increments.
  - With i_cim_ready low, all outputs hold (stall, no limit).
  - Transfer with o_cim_last=1: state→empty, counter→0, o_ready=1 the next cycle.
  - No bubble between consecutive planes while i_cim_ready is high.
  - DATA_SIZE=1: a single plane with o_cim_last=1.
- Ignored inputs:
  - i_write_enable and i_start in stream: ignored, storage unchanged.
  - i_cim_ready in empty: ignored.
- Reset mid-stream: immediate return to reset values; partial stream abandoned.
- No arithmetic beyond counters; data is stored unmodified.

Test Plan:
Small configuration for all scenarios: DATA_SIZE=4, INPUT_NEURONS=20, XBAR_SIZE=16, NUM_CHANNELS=2 → ELEMENTS_PER_TILE=4, PREV_H_TILES=5, NUM_ADDR=2, V_CIM_TILES=2.
1. Fill and stream:
   - Stimulus: write addr0 with i_data[h][c]=h*4+c, addr1 with h*4+2+c; pulse i_start; hold i_cim_ready=1.
   - Response: 4 consecutive planes with bits 0..3, plane b row r of tile0 = bit b of r.
   - Tile1 rows 0..3 = bits of 16..19; rows 4..15 = 0; o_cim_last on bit 3; o_ready=1 the cycle after.
2. Back-pressure:
   - Stimulus: toggle i_cim_ready 1,0,0,1,0,1,1.
   - Response: o_cim_bit sequence 0,1,1,1,2,2,3; o_cim_data stable while stalled.
3. Wrap and same-cycle start:
   - Stimulus: three writes (addr 0,1,0) with the third at i_start.
   - Response: addr0 holds the third data, stored before streaming begins.
4. Ignored writes:
   - Stimulus: write of all 0xF and i_start during stream.
   - Response: streamed planes unchanged; no second stream; o_ready stays 0 until the last transfer.
5. Async reset:
   - Stimulus: assert rst mid-cycle at bit 2.
   - Response: o_cim_valid=0 and o_ready=1 immediately; a subsequent stream with no writes outputs all-zero planes.
6. Reset values:
   - Stimulus: release reset.
   - Response: all outputs at reset values; i_cim_ready=1 in empty produces no valid.
